inst_prefetch: RTL and testbench
================================

INST_PREFETCH -- requirements
Module: inst_prefetch

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, SHALL set the fetch address loaded at reset.
REQ-002 Parameter DEPTH, default 16, SHALL set the byte-queue capacity in entries. Only the value 16 is required to be supported.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  in  1  SHALL be the asynchronous, active-high reset.
REQ-005 mem_req  out  1  SHALL indicate a memory read request is pending.
REQ-006 mem_addr  out  16  SHALL carry the byte address of the request.
REQ-007 mem_ack  in  1  SHALL signal read completion. mem_data is valid in the same cycle.
REQ-008 mem_data  in  8  SHALL carry the returned instruction byte.
REQ-009 redirect  in  1  SHALL request a flush and a restart of fetch at redirect_pc (branch/jump/interrupt).
REQ-010 redirect_pc  in  16  SHALL carry the new fetch address. It is sampled when redirect=1.
REQ-011 pop  in  1  SHALL cause the decoder to consume the head byte.
REQ-012 q_data  out  8  SHALL present the head byte of the queue.
REQ-013 q_valid  out  1  SHALL be 1 when and only when q_count is not 0.
REQ-014 q_count  out  5  SHALL give the number of queued bytes (0..16).
REQ-015 full  out  1  SHALL be 1 when and only when q_count equals 16.

Function
REQ-016 The FSM SHALL have three states:
- IDLE: no request pending.
- REQ: request pending, data to be kept.
- DISCARD: request pending, data to be dropped.
REQ-017 The byte queue SHALL be a circular buffer with 4-bit head/tail pointers that wrap from 15 to 0.
REQ-018 Memory handshake rules:
- mem_req and mem_addr SHALL be registered outputs.
- Once mem_req=1, mem_req and mem_addr SHALL stay stable until the cycle mem_ack=1.
- A request SHALL never be withdrawn early.
- mem_ack while mem_req=0 SHALL be ignored.
REQ-019 In IDLE with redirect=0 and q_count<16, the block SHALL enter REQ at the next edge, with mem_req=1 and mem_addr=fetch_pc.
REQ-020 In REQ, mem_ack=1 and redirect=0:
- mem_data SHALL be pushed at the tail.
- fetch_pc SHALL increment modulo 2^16 (16'hFFFF to 16'h0000).
- If (q_count + 1 - pop) < 16, the block SHALL stay in REQ with mem_addr = the new fetch_pc (back-to-back, one byte per cycle). Otherwise it SHALL go to IDLE.
REQ-021 Push and valid pop in the same cycle SHALL leave q_count unchanged. The pushed byte SHALL land behind the popped byte.
REQ-022 pop while q_valid=0 SHALL be ignored. No pointer or count change is allowed.
REQ-023 Redirect rules:
- redirect=1 SHALL empty the queue (q_count=0 at the next edge) and load fetch_pc=redirect_pc.
- A simultaneous pop SHALL be ignored.
REQ-024 Redirect in IDLE, or in REQ with mem_ack=1, SHALL go to REQ at the next edge with mem_addr=redirect_pc. Any mem_data in that cycle SHALL be dropped.
REQ-025 Redirect in REQ with mem_ack=0:
- The block SHALL go to DISCARD, keeping mem_req and mem_addr unchanged.
- On the later mem_ack, the data SHALL be dropped and the block SHALL go to REQ with mem_addr = the latched redirect_pc.
REQ-026 Redirect in DISCARD SHALL overwrite the latched target and remain in DISCARD. If mem_ack=1 in that same cycle, the block SHALL go to REQ with the newest redirect_pc.
REQ-027 Latency SHALL be one cycle:
- A byte acked at edge N SHALL be visible on q_data/q_valid after edge N.
- q_data SHALL be combinational from the head entry.
REQ-028 q_count SHALL never exceed 16 and never underflow. mem_req SHALL be 0 whenever full=1 and the state is IDLE.

Reset
REQ-029 While reset=1, independent of clk:
- state SHALL be IDLE, with mem_req=0 and mem_addr=RESET_PC.
- fetch_pc SHALL be RESET_PC.
- Pointers and q_count SHALL be 0, with q_valid=0 and full=0.
REQ-030 Queue storage contents SHALL NOT require reset. q_data is don't-care while q_valid=0.
REQ-031 Reset asserted mid-request SHALL abandon the transaction. A mem_ack arriving after reset release without a new request SHALL be ignored.

Verification
REQ-032 Startup: release reset, mem_ack=1 every cycle, pop=0 -> mem_req=1 at edge 1 with addr 0000. Then 0000..000F are fetched back-to-back, full=1 after the 16th ack, and mem_req=0 with q_count=16 thereafter.
REQ-033 Streaming: full queue, pop=1 continuously, ack every cycle -> q_count holds between 15 and 16, and q_data sequence equals addresses' data in order with no gaps or duplicates.
REQ-034 Redirect during wait: mem_req=1 at addr 0005 with ack held low, redirect to 1234 -> mem_addr stays 0005 until ack, that byte is not queued, and the next request is at 1234 with q_count=0.
REQ-035 Redirect coincident with ack plus pop, q_count=3 -> q_count=0 next cycle, acked byte dropped, and the next mem_addr is redirect_pc.
REQ-036 Wrap: redirect to FFFE with ack every cycle -> addresses FFFE, FFFF, 0000, 0001, and queue pointers wrap 15 to 0 without data loss.
REQ-037 Asynchronous reset pulse mid-stream, between clock edges -> outputs reach the reset values immediately. An ack after release without mem_req changes nothing.

Source files
------------

// File: rtl/inst_prefetch_if.sv
// Bundle of memory-read handshake, redirect and byte-queue signals between the
// instruction prefetcher (master) and its environment (slave).
interface inst_prefetch_if;
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned CNT_W  = 5;

   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_data;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_pc;
   logic              pop;
   logic [DATA_W-1:0] q_data;
   logic              q_valid;
   logic [CNT_W-1:0]  q_count;
   logic              full;

   modport master (
      output mem_req, mem_addr, q_data, q_valid, q_count, full,
      input  mem_ack, mem_data, redirect, redirect_pc, pop
   );

   modport slave (
      input  mem_req, mem_addr, q_data, q_valid, q_count, full,
      output mem_ack, mem_data, redirect, redirect_pc, pop
   );
endinterface

// File: rtl/inst_prefetch.sv
// Instruction prefetcher: fetches bytes one at a time from memory into a
// circular byte queue, with flush-and-restart on redirect.
module inst_prefetch #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int unsigned DEPTH    = 16
) (
   input  logic            clk,
   input  logic            reset,
   inst_prefetch_if.master pf
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

   state_t           state;
   state_t           state_nxt;
   logic             req_nxt;
   logic [15:0]      addr_nxt;
   logic [15:0]      pc;
   logic [15:0]      pc_nxt;
   logic             push;
   logic             pop_ok;
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;
   logic [7:0]       store [DEPTH];

   // A redirect cancels any pop in the same cycle.
   assign pop_ok = pf.pop & (count != '0) & ~pf.redirect;

   // Next-state logic; pc doubles as the latched redirect target in DISCARD.
   always_comb begin
      state_nxt = state;
      addr_nxt  = pf.mem_addr;
      pc_nxt    = pc;
      push      = 1'b0;
      if (pf.redirect) pc_nxt = pf.redirect_pc;
      unique case (state)
         IDLE: begin
            if (pf.redirect) begin
               state_nxt = REQ;
               addr_nxt  = pf.redirect_pc;
            end else if (count < CNT_W'(DEPTH)) begin
               state_nxt = REQ;
               addr_nxt  = pc;
            end
         end
         REQ: begin
            if (pf.redirect) begin
               if (pf.mem_ack) addr_nxt = pf.redirect_pc;
               else            state_nxt = DISCARD;
            end else if (pf.mem_ack) begin
               push   = 1'b1;
               pc_nxt = pc + 16'd1;
               if (CNT_W'(count + CNT_W'(1) - CNT_W'(pop_ok)) < CNT_W'(DEPTH))
                  addr_nxt = pc + 16'd1;
               else
                  state_nxt = IDLE;
            end
         end
         DISCARD: begin
            if (pf.mem_ack) begin
               state_nxt = REQ;
               addr_nxt  = pf.redirect ? pf.redirect_pc : pc;
            end
         end
         default: state_nxt = IDLE;
      endcase
      req_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         pf.mem_req  <= 1'b0;
         pf.mem_addr <= RESET_PC;
         pc          <= RESET_PC;
      end else begin
         state       <= state_nxt;
         pf.mem_req  <= req_nxt;
         pf.mem_addr <= addr_nxt;
         pc          <= pc_nxt;
      end
   end

   // Queue pointers and occupancy; redirect empties the queue.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (pf.redirect) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push)   tail <= tail + PTR_W'(1);
         if (pop_ok) head <= head + PTR_W'(1);
         count <= CNT_W'(count + CNT_W'(push) - CNT_W'(pop_ok));
      end
   end

   always_ff @(posedge clk) begin
      if (push) store[tail] <= pf.mem_data;
   end

   assign pf.q_data  = store[head];
   assign pf.q_valid = (count != '0);
   assign pf.q_count = count;
   assign pf.full    = (count == CNT_W'(DEPTH));
endmodule

// File: tb/tb_inst_prefetch.sv
// Randomized bench for inst_prefetch against a transaction-level model built
// from a byte queue, the fetch pointer and the outstanding-request status.
module tb_inst_prefetch;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   inst_prefetch_if pf ();

   inst_prefetch #(.RESET_PC(16'h0000), .DEPTH(16)) dut (
      .clk   (clk),
      .reset (reset),
      .pf    (pf)
   );

   // Memory image: every address returns a fixed, address-derived byte.
   function automatic logic [7:0] mem_byte(input logic [15:0] a);
      return a[7:0] ^ {a[14:8], a[15]} ^ 8'h3C;
   endfunction

   assign pf.mem_data = mem_byte(pf.mem_addr);

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   bit          m_pend;
   bit          m_drop;
   logic [15:0] m_pc;
   logic [15:0] m_addr;
   logic [7:0]  m_q [$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pend = 1'b0;
      m_drop = 1'b0;
      m_pc   = 16'h0000;
      m_addr = 16'h0000;
      m_q.delete();
   endtask

   // One clock edge of the reference behaviour, given the inputs held before it.
   task automatic model_step(input bit r, input logic [15:0] rpc, input bit p, input bit a);
      int pre  = m_q.size();
      bit done = m_pend && a;
      if (!r && p && pre > 0) void'(m_q.pop_front());
      if (done && !m_drop && !r) m_q.push_back(mem_byte(m_addr));
      if (r) begin
         m_q.delete();
         m_pc = rpc;
      end
      if (!m_pend) begin
         if (r || pre < 16) begin
            m_pend = 1'b1;
            m_drop = 1'b0;
            m_addr = m_pc;
         end
      end else if (done) begin
         if (r || m_drop) begin
            m_drop = 1'b0;
            m_addr = m_pc;
         end else begin
            m_pc = m_pc + 16'd1;
            if (m_q.size() < 16) m_addr = m_pc;
            else                 m_pend = 1'b0;
         end
      end else if (r) begin
         m_drop = 1'b1;
      end
   endtask

   task automatic check_outputs();
      chk("mem_req", 32'(pf.mem_req), 32'(m_pend));
      if (m_pend) chk("mem_addr", 32'(pf.mem_addr), 32'(m_addr));
      chk("q_count", 32'(pf.q_count), 32'(m_q.size()));
      chk("q_valid", 32'(pf.q_valid), 32'(m_q.size() != 0));
      chk("full", 32'(pf.full), 32'(m_q.size() == 16));
      if (m_q.size() > 0) chk("q_data", 32'(pf.q_data), 32'(m_q[0]));
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_mem_req"}, 32'(pf.mem_req), 32'(0));
      chk({tag, "_mem_addr"}, 32'(pf.mem_addr), 32'h0000);
      chk({tag, "_q_count"}, 32'(pf.q_count), 32'(0));
      chk({tag, "_q_valid"}, 32'(pf.q_valid), 32'(0));
      chk({tag, "_full"}, 32'(pf.full), 32'(0));
   endtask

   task automatic cycle(input bit r, input logic [15:0] rpc, input bit p, input bit a);
      pf.redirect    = r;
      pf.redirect_pc = rpc;
      pf.pop         = p;
      pf.mem_ack     = a;
      @(posedge clk);
      model_step(r, rpc, p, a);
      #1;
      check_outputs();
   endtask

   task automatic do_reset();
      reset          = 1'b1;
      pf.redirect    = 1'b0;
      pf.redirect_pc = 16'h0000;
      pf.pop         = 1'b0;
      pf.mem_ack     = 1'b0;
      model_reset();
      #3;
      check_reset_values("reset");
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      do_reset();

      // Startup fill: 16 back-to-back fetches, then request stops at full.
      repeat (20) cycle(1'b0, 16'h0, 1'b0, 1'b1);
      chk("startup_count", 32'(pf.q_count), 32'(16));
      chk("startup_req_off", 32'(pf.mem_req), 32'(0));

      // Streaming with continuous pop and ack.
      repeat (40) cycle(1'b0, 16'h0, 1'b1, 1'b1);

      // Redirect while a request waits for ack.
      do_reset();
      cycle(1'b0, 16'h0, 1'b0, 1'b0);
      repeat (5) cycle(1'b0, 16'h0, 1'b0, 1'b1);
      chk("wait_addr", 32'(pf.mem_addr), 32'h0005);
      cycle(1'b1, 16'h1234, 1'b0, 1'b0);
      repeat (3) cycle(1'b0, 16'h0, 1'b0, 1'b0);
      chk("wait_addr_hold", 32'(pf.mem_addr), 32'h0005);
      cycle(1'b0, 16'h0, 1'b0, 1'b1);
      chk("wait_count_zero", 32'(pf.q_count), 32'(0));
      chk("wait_new_addr", 32'(pf.mem_addr), 32'h1234);

      // Redirect coincident with ack and pop while three bytes are queued.
      do_reset();
      cycle(1'b0, 16'h0, 1'b0, 1'b0);
      repeat (3) cycle(1'b0, 16'h0, 1'b0, 1'b1);
      chk("three_queued", 32'(pf.q_count), 32'(3));
      cycle(1'b1, 16'hABCD, 1'b1, 1'b1);
      chk("coinc_count", 32'(pf.q_count), 32'(0));
      chk("coinc_addr", 32'(pf.mem_addr), 32'hABCD);

      // Address wrap at 16'hFFFF plus queue pointer wrap.
      cycle(1'b1, 16'hFFFE, 1'b0, 1'b1);
      chk("wrap_addr0", 32'(pf.mem_addr), 32'hFFFE);
      cycle(1'b0, 16'h0, 1'b0, 1'b1);
      chk("wrap_addr1", 32'(pf.mem_addr), 32'hFFFF);
      cycle(1'b0, 16'h0, 1'b0, 1'b1);
      chk("wrap_addr2", 32'(pf.mem_addr), 32'h0000);
      repeat (40) cycle(1'b0, 16'h0, 1'($urandom_range(1, 0)), 1'b1);

      // Asynchronous reset pulse between clock edges.
      repeat (5) cycle(1'b0, 16'h0, 1'b1, 1'b1);
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      check_reset_values("async");
      #1;
      reset = 1'b0;
      cycle(1'b0, 16'h0, 1'b0, 1'b1);
      chk("post_reset_count", 32'(pf.q_count), 32'(0));

      // Random phases with varying pop pressure.
      for (int ph = 0; ph < 6; ph++) begin
         for (int k = 0; k < 400; k++) begin
            bit          r;
            bit          p;
            bit          a;
            logic [15:0] rpc;
            r   = ($urandom_range(24, 0) == 0);
            rpc = ($urandom_range(3, 0) == 0) ? 16'hFFF8 + 16'($urandom_range(7, 0))
                                              : 16'($urandom);
            p   = ($urandom_range(5, 0) < ph);
            a   = ($urandom_range(3, 0) != 0);
            cycle(r, rpc, p, a);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
